// File: rtl/axis_xgmii_tx.sv
// axis_xgmii_tx: 64-bit AXI-Stream to XGMII TX framer (preamble, pad, zero FCS slot, /T/, IFG, /E/ abort).
// Latency: one registered column per clk; a start request in IDLE yields the preamble on the next edge.
// Backpressure: tready is high only in DATA/DROP; an empty input in DATA aborts the frame with /E/.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_axis_tdata      64-bit payload, byte 0 in bits [7:0], byte 0 sent first
//   s_axis_tkeep      byte enables, only honoured on the tlast beat
//   s_axis_tvalid     beat valid
//   s_axis_tlast      last beat of frame
//   s_axis_tready     beat accepted when tvalid && tready
//   xgmii_txo         registered XGMII TX column (8 data lanes + 8 ctrl bits)

package axis_xgmii_tx_pkg;
    typedef struct packed {
        logic [7:0][7:0] data;   // data[i] is lane i
        logic [7:0]      ctrl;   // ctrl[i] flags lane i as a control character
    } xgmii_t;
endpackage

module axis_xgmii_tx
    import axis_xgmii_tx_pkg::*;
#(
    parameter int MIN_PAYLOAD = 60,
    parameter int IFG_BYTES   = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output xgmii_t      xgmii_txo
);

    localparam logic [7:0] C_IDLE  = 8'h07;
    localparam logic [7:0] C_TERM  = 8'hFD;
    localparam logic [7:0] C_ERROR = 8'hFE;

    localparam xgmii_t IDLE_COL = {{8{C_IDLE}}, 8'hFF};
    localparam xgmii_t ERR_COL  = {{8{C_ERROR}}, 8'hFF};
    localparam xgmii_t PRE_COL  = {64'hD5555555555555FB, 8'h01};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_TAIL,
        ST_IFG,
        ST_DROP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] rem_q, rem_d;       // tail zero bytes still owed after the last beat
    logic [15:0] ifg_q, ifg_d;       // full idle columns still owed before the next start
    xgmii_t      col_q, col_d;

    // Idle columns needed after a terminate column whose /T/ sits in term_lane;
    // the idle lanes above /T/ already count toward the gap.
    function automatic logic [15:0] ifg_cols(input int term_lane);
        int need;
        need = IFG_BYTES - (7 - term_lane);
        if (need < 0) begin
            need = 0;
        end
        return 16'((need + 7) / 8);
    endfunction

    always_comb begin
        int k;
        int total;
        int tail;
        int lane;

        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        rem_d         = rem_q;
        ifg_d         = ifg_q;
        col_d         = IDLE_COL;
        s_axis_tready = 1'b0;
        k             = 0;
        total         = 0;
        tail          = 0;
        lane          = 0;

        case (state_q)
            ST_IDLE: begin
                if (s_axis_tvalid) begin
                    col_d      = PRE_COL;
                    byte_cnt_d = '0;
                    state_d    = ST_DATA;
                end
            end

            ST_DATA: begin
                s_axis_tready = !rst;
                if (!s_axis_tvalid) begin
                    // Underrun: poison the frame and swallow the rest of it.
                    col_d   = ERR_COL;
                    ifg_d   = ifg_cols(7);
                    state_d = ST_DROP;
                end else if (!s_axis_tlast) begin
                    col_d.data = s_axis_tdata;
                    col_d.ctrl = 8'h00;
                    byte_cnt_d = (byte_cnt_q > 16'hFFF7) ? 16'hFFFF : byte_cnt_q + 16'd8;
                end else begin
                    for (int i = 0; i < 8; i++) begin
                        k = k + int'(s_axis_tkeep[i]);
                    end
                    total = int'(byte_cnt_q) + k;
                    tail  = ((total < MIN_PAYLOAD) ? (MIN_PAYLOAD - total) : 0) + 4;
                    for (int i = 0; i < 8; i++) begin
                        if (i < k) begin
                            col_d.data[i] = s_axis_tdata[8*i +: 8];
                            col_d.ctrl[i] = 1'b0;
                        end else if (i < k + tail) begin
                            col_d.data[i] = 8'h00;
                            col_d.ctrl[i] = 1'b0;
                        end else if (i == k + tail) begin
                            col_d.data[i] = C_TERM;
                            col_d.ctrl[i] = 1'b1;
                        end else begin
                            col_d.data[i] = C_IDLE;
                            col_d.ctrl[i] = 1'b1;
                        end
                    end
                    byte_cnt_d = '0;
                    if (k + tail <= 7) begin
                        ifg_d   = ifg_cols(k + tail);
                        state_d = (ifg_cols(k + tail) == 16'd0) ? ST_IDLE : ST_IFG;
                    end else begin
                        rem_d   = 16'(tail - (8 - k));
                        state_d = ST_TAIL;
                    end
                end
            end

            ST_TAIL: begin
                if (rem_q >= 16'd8) begin
                    // rem == 8 also lands here: /T/ then goes to lane 0 next cycle.
                    col_d.data = '0;
                    col_d.ctrl = 8'h00;
                    rem_d      = rem_q - 16'd8;
                end else begin
                    lane = int'(rem_q);
                    for (int i = 0; i < 8; i++) begin
                        if (i < lane) begin
                            col_d.data[i] = 8'h00;
                            col_d.ctrl[i] = 1'b0;
                        end else if (i == lane) begin
                            col_d.data[i] = C_TERM;
                            col_d.ctrl[i] = 1'b1;
                        end else begin
                            col_d.data[i] = C_IDLE;
                            col_d.ctrl[i] = 1'b1;
                        end
                    end
                    ifg_d   = ifg_cols(lane);
                    state_d = (ifg_cols(lane) == 16'd0) ? ST_IDLE : ST_IFG;
                end
            end

            ST_IFG: begin
                if (ifg_q <= 16'd1) begin
                    ifg_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    ifg_d = ifg_q - 16'd1;
                end
            end

            ST_DROP: begin
                s_axis_tready = !rst;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = (ifg_q == 16'd0) ? ST_IDLE : ST_IFG;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            rem_q      <= '0;
            ifg_q      <= '0;
            col_q      <= IDLE_COL;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            rem_q      <= rem_d;
            ifg_q      <= ifg_d;
            col_q      <= col_d;
        end
    end

    assign xgmii_txo = col_q;

endmodule
